jtpopeye_rom_arb: RTL and testbench

JTPOPEYE_ROM_ARB -- requirements
Module: jtpopeye_rom_arb

---
 rtl/jtpopeye_rom_arb.sv | 227 ++++++++++++++++++++++
 tb/tb_jtpopeye_rom_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_rom_arb.sv
// ---------------------------------------------------------------------------
// jtpopeye_rom_arb
// Arbitrates one SDRAM port between a ROM download writer and two cached
// read requesters (cpu, vid). Download writes go through a one-entry holding
// buffer and always take priority over reads. Each reader has a one-word
// cache (address tag, data word, valid bit); ok is a combinational hit.
//
// Ports
//   clk_rom_i, rst_i            : clock, synchronous active-high reset
//   downloading_i               : ROM download in progress (blocks reads)
//   prog_addr_i/data_i/mask_i/we_i : download write (mask active-low)
//   cpu_*/vid_*                 : level requests, held until ok
//   sdram_addr_o/din_o/dqm_o    : access address, write word, byte mask
//   sdram_rd_o/wr_o             : access request levels
//   sdram_ack_i, data_rdy_i, sdram_dout_i : SDRAM handshake and read data
//   prog_ovf_o                  : sticky download-overflow flag
// ---------------------------------------------------------------------------
module jtpopeye_rom_arb #(
   parameter int AW        = 22,
   parameter bit VID_FIRST = 1'b1
) (
   input  logic          clk_rom_i,
   input  logic          rst_i,
   input  logic          downloading_i,
   input  logic [AW-1:0] prog_addr_i,
   input  logic [7:0]    prog_data_i,
   input  logic [1:0]    prog_mask_i,
   input  logic          prog_we_i,
   input  logic          cpu_req_i,
   input  logic [AW-1:0] cpu_addr_i,
   output logic [15:0]   cpu_data_o,
   output logic          cpu_ok_o,
   input  logic          vid_req_i,
   input  logic [AW-1:0] vid_addr_i,
   output logic [15:0]   vid_data_o,
   output logic          vid_ok_o,
   output logic [AW-1:0] sdram_addr_o,
   output logic [15:0]   sdram_din_o,
   output logic [1:0]    sdram_dqm_o,
   output logic          sdram_rd_o,
   output logic          sdram_wr_o,
   input  logic          sdram_ack_i,
   input  logic          data_rdy_i,
   input  logic [15:0]   sdram_dout_i,
   output logic          prog_ovf_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          dl_q;
   logic          buf_full_q;
   logic [AW-1:0] buf_addr_q;
   logic [7:0]    buf_data_q;
   logic [1:0]    buf_mask_q;
   logic          prog_ovf_q;
   logic [AW-1:0] sdram_addr_q;
   logic [15:0]   sdram_din_q;
   logic [1:0]    sdram_dqm_q;
   logic [AW-1:0] cpu_tag_q, vid_tag_q;
   logic [15:0]   cpu_word_q, vid_word_q;
   logic          cpu_valid_q, vid_valid_q;
   logic          last_vid_q;   // port served by the most recent read
   logic          win_vid_q;    // port owning the read in flight

   logic dl_rise_s, cpu_hit_s, vid_hit_s, cpu_cand_s, vid_cand_s;
   logic rd_allow_s, pick_vid_s, start_rd_s, start_wr_s, wr_done_s, fill_s;
   logic buf_take_s, buf_drop_s;

   assign dl_rise_s  = downloading_i & ~dl_q;
   assign cpu_hit_s  = cpu_req_i & cpu_valid_q & (cpu_addr_i == cpu_tag_q) & ~downloading_i;
   assign vid_hit_s  = vid_req_i & vid_valid_q & (vid_addr_i == vid_tag_q) & ~downloading_i;
   assign cpu_cand_s = cpu_req_i & ~cpu_hit_s;
   assign vid_cand_s = vid_req_i & ~vid_hit_s;
   assign rd_allow_s = (state_q == S_IDLE) & ~buf_full_q & ~downloading_i;
   // vid wins if it is the only candidate, or if both compete and cpu went last
   assign pick_vid_s = vid_cand_s & (~cpu_cand_s | ~last_vid_q);
   assign start_rd_s = rd_allow_s & (cpu_cand_s | vid_cand_s);
   assign start_wr_s = (state_q == S_IDLE) & buf_full_q;
   assign wr_done_s  = (state_q == S_WRITE) & sdram_ack_i;
   assign fill_s     = (state_q == S_WAIT) & data_rdy_i;
   // the slot frees on the ack edge, so a strobe on that cycle still fits
   assign buf_take_s = prog_we_i & (~buf_full_q | wr_done_s);
   assign buf_drop_s = prog_we_i & buf_full_q & ~wr_done_s;

   assign cpu_ok_o    = cpu_hit_s;
   assign vid_ok_o    = vid_hit_s;
   assign cpu_data_o  = cpu_word_q;
   assign vid_data_o  = vid_word_q;
   assign sdram_addr_o = sdram_addr_q;
   assign sdram_din_o  = sdram_din_q;
   assign sdram_dqm_o  = sdram_dqm_q;
   assign prog_ovf_o   = prog_ovf_q;

   // FSM state register
   always_ff @(posedge clk_rom_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; a pending write pre-empts any read
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_wr_s) state_d = S_WRITE;
            else if (start_rd_s) state_d = S_READ;
            else state_d = S_IDLE;
         end
         S_WRITE: begin
            if (sdram_ack_i) state_d = S_IDLE;
            else state_d = S_WRITE;
         end
         S_READ: begin
            if (sdram_ack_i) state_d = S_WAIT;
            else state_d = S_READ;
         end
         S_WAIT: begin
            if (data_rdy_i) state_d = S_IDLE;
            else state_d = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: access request levels
   always_comb begin
      sdram_rd_o = 1'b0;
      sdram_wr_o = 1'b0;
      case (state_q)
         S_WRITE: sdram_wr_o = 1'b1;
         S_READ:  sdram_rd_o = 1'b1;
         default: begin
            sdram_rd_o = 1'b0;
            sdram_wr_o = 1'b0;
         end
      endcase
   end

   // download holding buffer and sticky overflow flag
   always_ff @(posedge clk_rom_i) begin
      if (rst_i) begin
         dl_q       <= 1'b0;
         buf_full_q <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= 8'h00;
         buf_mask_q <= 2'b11;
         prog_ovf_q <= 1'b0;
      end else begin
         dl_q       <= downloading_i;
         prog_ovf_q <= (prog_ovf_q & ~dl_rise_s) | buf_drop_s;
         if (buf_take_s) begin
            buf_full_q <= 1'b1;
            buf_addr_q <= prog_addr_i;
            buf_data_q <= prog_data_i;
            buf_mask_q <= prog_mask_i;
         end else if (wr_done_s) begin
            buf_full_q <= 1'b0;
         end
      end
   end

   // SDRAM address/data/mask, loaded when an access is launched
   always_ff @(posedge clk_rom_i) begin
      if (rst_i) begin
         sdram_addr_q <= '0;
         sdram_din_q  <= 16'h0000;
         sdram_dqm_q  <= 2'b11;
      end else if (start_wr_s) begin
         sdram_addr_q <= buf_addr_q;
         sdram_din_q  <= {buf_data_q, buf_data_q};
         sdram_dqm_q  <= buf_mask_q;
      end else if (start_rd_s) begin
         sdram_addr_q <= pick_vid_s ? vid_addr_i : cpu_addr_i;
         sdram_dqm_q  <= 2'b00;   // reads return the full word
      end
   end

   // per-port caches and round-robin pointer
   always_ff @(posedge clk_rom_i) begin
      if (rst_i) begin
         cpu_tag_q   <= '0;
         vid_tag_q   <= '0;
         cpu_word_q  <= 16'h0000;
         vid_word_q  <= 16'h0000;
         cpu_valid_q <= 1'b0;
         vid_valid_q <= 1'b0;
         last_vid_q  <= ~VID_FIRST;
         win_vid_q   <= VID_FIRST;
      end else begin
         if (start_rd_s) begin
            win_vid_q  <= pick_vid_s;
            last_vid_q <= pick_vid_s;
            if (pick_vid_s) begin
               vid_tag_q   <= vid_addr_i;
               vid_valid_q <= 1'b0;
            end else begin
               cpu_tag_q   <= cpu_addr_i;
               cpu_valid_q <= 1'b0;
            end
         end
         if (fill_s) begin
            if (win_vid_q) begin
               vid_word_q  <= sdram_dout_i;
               vid_valid_q <= 1'b1;
            end else begin
               cpu_word_q  <= sdram_dout_i;
               cpu_valid_q <= 1'b1;
            end
         end
         // a new download invalidates everything, including a fill landing now
         if (dl_rise_s) begin
            cpu_valid_q <= 1'b0;
            vid_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
module tb_jtpopeye_rom_arb;
   localparam int AW = 22;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, downloading, prog_we;
   logic [AW-1:0] prog_addr;
   logic [7:0]    prog_data;
   logic [1:0]    prog_mask;
   logic          cpu_req, vid_req;
   logic [AW-1:0] cpu_addr, vid_addr;
   logic [15:0]   cpu_data, vid_data;
   logic          cpu_ok, vid_ok;
   logic [AW-1:0] sdram_addr;
   logic [15:0]   sdram_din;
   logic [1:0]    sdram_dqm;
   logic          sdram_rd, sdram_wr, sdram_ack, data_rdy;
   logic [15:0]   sdram_dout;
   logic          prog_ovf;

   // SDRAM side: hand-driven by directed tests or by the random responder
   logic          auto_en = 1'b0;
   logic          man_ack, man_rdy;
   logic [15:0]   man_dout;
   logic          auto_ack = 1'b0, auto_rdy = 1'b0, ack_rd = 1'b0, pend_on = 1'b0;
   logic [15:0]   auto_dout = 16'h0000;
   logic [AW-1:0] pend_addr = '0;
   int            pend_cnt = 0;

   assign sdram_ack  = auto_en ? auto_ack  : man_ack;
   assign data_rdy   = auto_en ? auto_rdy  : man_rdy;
   assign sdram_dout = auto_en ? auto_dout : man_dout;

   int checks, failures;

   jtpopeye_rom_arb #(.AW(AW), .VID_FIRST(1'b1)) dut (
      .clk_rom_i(clk), .rst_i(rst), .downloading_i(downloading),
      .prog_addr_i(prog_addr), .prog_data_i(prog_data), .prog_mask_i(prog_mask), .prog_we_i(prog_we),
      .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_data_o(cpu_data), .cpu_ok_o(cpu_ok),
      .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_data_o(vid_data), .vid_ok_o(vid_ok),
      .sdram_addr_o(sdram_addr), .sdram_din_o(sdram_din), .sdram_dqm_o(sdram_dqm),
      .sdram_rd_o(sdram_rd), .sdram_wr_o(sdram_wr), .sdram_ack_i(sdram_ack),
      .data_rdy_i(data_rdy), .sdram_dout_i(sdram_dout), .prog_ovf_o(prog_ovf)
   );

   // ROM contents seen by the random test
   function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] t;
      t = {10'd0, a} * 32'h9E37_79B1;
      return t[31:16] ^ t[15:0];
   endfunction

   // random-latency SDRAM model: random ack, then data 0..3 cycles later
   always @(negedge clk) begin
      if (!auto_en) begin
         auto_ack <= 1'b0; auto_rdy <= 1'b0; pend_on <= 1'b0; ack_rd <= 1'b0;
      end else begin
         ack_rd   <= sdram_rd;
         auto_ack <= (sdram_rd | sdram_wr) && ($urandom_range(0, 2) == 0);
         auto_rdy <= 1'b0;
         if (auto_ack && ack_rd) begin
            pend_on   <= 1'b1;
            pend_addr <= sdram_addr;
            pend_cnt  <= $urandom_range(0, 3);
         end else if (pend_on) begin
            if (pend_cnt == 0) begin
               auto_rdy  <= 1'b1;
               auto_dout <= mem_word(pend_addr);
               pend_on   <= 1'b0;
            end else begin
               pend_cnt <= pend_cnt - 1;
            end
         end
      end
   end

   // serve one read by hand; returns at the cycle after data_rdy
   task automatic do_read(input logic [15:0] dout, output logic [AW-1:0] addr_seen,
                          output bit got, output bit dropped);
      got = 1'b0; dropped = 1'b0; addr_seen = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (sdram_rd) begin got = 1'b1; addr_seen = sdram_addr; end
      end
      if (got) begin
         man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
         dropped = !sdram_rd;
         man_rdy = 1'b1; man_dout = dout; @(negedge clk); man_rdy = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req = 1'b1; vid_req = 1'b1; cpu_addr = '0; vid_addr = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({sdram_rd, sdram_wr, sdram_dqm, prog_ovf, cpu_ok, vid_ok} !== 7'b0011000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0011000", {sdram_rd, sdram_wr, sdram_dqm, prog_ovf, cpu_ok, vid_ok});
      end
      checks++;
      if (sdram_addr !== 22'h000000 || sdram_din !== 16'h0000) begin
         failures++; $display("FAIL reset_addr_din got=%h/%h exp=0/0", sdram_addr, sdram_din);
      end
      checks++;
      if (cpu_data !== 16'h0000 || vid_data !== 16'h0000) begin
         failures++; $display("FAIL reset_data got=%h/%h exp=0/0", cpu_data, vid_data);
      end
      rst = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_download();
      int cnt;
      logic [AW+17:0] cap;
      downloading = 1'b1; @(negedge clk);
      prog_addr = 22'h000010; prog_data = 8'hA5; prog_mask = 2'b10; prog_we = 1'b1;
      @(negedge clk); prog_we = 1'b0;
      cnt = 0; cap = '0;
      for (int i = 0; i < 20; i++) begin
         if (sdram_wr) begin
            cnt++;
            if (cnt == 1) cap = {sdram_addr, sdram_din, sdram_dqm};
            man_ack = (cnt == 4);
         end else if (cnt > 0) begin
            break;
         end
         @(negedge clk);
      end
      man_ack = 1'b0;
      checks++;
      if (cnt != 4) begin failures++; $display("FAIL dl_wr_cycles got=%0d exp=4", cnt); end
      checks++;
      if (cap !== {22'h000010, 16'hA5A5, 2'b10}) begin
         failures++; $display("FAIL dl_wr_fields got=%h exp=%h", cap, {22'h000010, 16'hA5A5, 2'b10});
      end
      checks++;
      if (prog_ovf !== 1'b0) begin failures++; $display("FAIL dl_ovf got=%b exp=0", prog_ovf); end
   endtask

   task automatic test_overflow();
      bit seen, extra;
      prog_addr = 22'h000020; prog_data = 8'h11; prog_mask = 2'b00; prog_we = 1'b1;
      @(negedge clk); prog_we = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = sdram_wr; end
      checks++;
      if (!seen || sdram_addr !== 22'h000020) begin
         failures++; $display("FAIL ovf_first_wr got=%b/%h exp=1/000020", seen, sdram_addr);
      end
      prog_addr = 22'h000030; prog_data = 8'h22; prog_mask = 2'b01; prog_we = 1'b1;
      @(negedge clk); prog_we = 1'b0;
      checks++;
      if (prog_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", prog_ovf); end
      man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
      extra = 1'b0;
      repeat (6) begin @(negedge clk); if (sdram_wr) extra = 1'b1; end
      checks++;
      if (extra || sdram_addr !== 22'h000020) begin
         failures++; $display("FAIL ovf_dropped got=%b/%h exp=0/000020", extra, sdram_addr);
      end
      downloading = 1'b0; repeat (2) @(negedge clk);
      checks++;
      if (prog_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", prog_ovf); end
      downloading = 1'b1; @(negedge clk);
      checks++;
      if (prog_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", prog_ovf); end
   endtask

   task automatic test_we_on_ack();
      bit seen;
      prog_addr = 22'h000040; prog_data = 8'h3C; prog_mask = 2'b01; prog_we = 1'b1;
      @(negedge clk); prog_we = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = sdram_wr; end
      man_ack = 1'b1;
      prog_addr = 22'h000041; prog_data = 8'hC3; prog_mask = 2'b10; prog_we = 1'b1;
      @(negedge clk); man_ack = 1'b0; prog_we = 1'b0;
      checks++;
      if (!seen || prog_ovf !== 1'b0) begin
         failures++; $display("FAIL weack_ovf got=%b/%b exp=1/0", seen, prog_ovf);
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = sdram_wr; end
      checks++;
      if (!seen || {sdram_addr, sdram_din, sdram_dqm} !== {22'h000041, 16'hC3C3, 2'b10}) begin
         failures++; $display("FAIL weack_second got=%b/%h/%h/%b exp=1/000041/c3c3/10", seen, sdram_addr, sdram_din, sdram_dqm);
      end
      man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
      downloading = 1'b0; @(negedge clk);
   endtask

   task automatic test_contention();
      logic [AW-1:0] a; bit got, dropped;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      cpu_req = 1'b1; cpu_addr = 22'h200005; vid_req = 1'b1; vid_addr = 22'h000005;
      do_read(16'hBEEF, a, got, dropped);
      checks++;
      if (!got || !dropped || a !== 22'h000005) begin
         failures++; $display("FAIL cont_first got=%b/%b/%h exp=1/1/000005", got, dropped, a);
      end
      checks++;
      if ({vid_ok, cpu_ok} !== 2'b10 || vid_data !== 16'hBEEF) begin
         failures++; $display("FAIL cont_vid_ok got=%b/%h exp=10/beef", {vid_ok, cpu_ok}, vid_data);
      end
      do_read(16'hCAFE, a, got, dropped);
      checks++;
      if (!got || a !== 22'h200005) begin
         failures++; $display("FAIL cont_second got=%b/%h exp=1/200005", got, a);
      end
      checks++;
      if ({vid_ok, cpu_ok} !== 2'b11 || cpu_data !== 16'hCAFE) begin
         failures++; $display("FAIL cont_cpu_ok got=%b/%h exp=11/cafe", {vid_ok, cpu_ok}, cpu_data);
      end
   endtask

   task automatic test_cache_hit();
      bit any_rd, lost;
      cpu_req = 1'b0; @(negedge clk);
      checks++;
      if (cpu_ok !== 1'b0) begin failures++; $display("FAIL hit_noreq got=%b exp=0", cpu_ok); end
      cpu_req = 1'b1; #1;
      checks++;
      if (cpu_ok !== 1'b1 || cpu_data !== 16'hCAFE) begin
         failures++; $display("FAIL hit_same_cycle got=%b/%h exp=1/cafe", cpu_ok, cpu_data);
      end
      any_rd = 1'b0; lost = 1'b0;
      repeat (4) begin @(negedge clk); if (sdram_rd) any_rd = 1'b1; if (!cpu_ok) lost = 1'b1; end
      checks++;
      if (any_rd || lost) begin failures++; $display("FAIL hit_no_rd got=%b/%b exp=0/0", any_rd, lost); end
      cpu_addr = 22'h000005; #1;
      checks++;
      if (cpu_ok !== 1'b0) begin failures++; $display("FAIL hit_msb_cmp got=%b exp=0", cpu_ok); end
      cpu_addr = 22'h200005;
      @(negedge clk);
   endtask

   task automatic test_download_start();
      logic [AW-1:0] a; bit got, dropped, any_rd, any_ok;
      downloading = 1'b1; #1;
      checks++;
      if ({cpu_ok, vid_ok} !== 2'b00) begin failures++; $display("FAIL dls_ok got=%b exp=00", {cpu_ok, vid_ok}); end
      any_rd = 1'b0; any_ok = 1'b0;
      repeat (5) begin @(negedge clk); if (sdram_rd) any_rd = 1'b1; if (cpu_ok | vid_ok) any_ok = 1'b1; end
      checks++;
      if (any_rd || any_ok) begin failures++; $display("FAIL dls_blocked got=%b/%b exp=0/0", any_rd, any_ok); end
      downloading = 1'b0; #1;
      checks++;
      if ({cpu_ok, vid_ok} !== 2'b00) begin failures++; $display("FAIL dls_invalid got=%b exp=00", {cpu_ok, vid_ok}); end
      do_read(16'h1111, a, got, dropped);
      checks++;
      if (!got || a !== 22'h000005) begin failures++; $display("FAIL dls_vid_rd got=%b/%h exp=1/000005", got, a); end
      do_read(16'h2222, a, got, dropped);
      checks++;
      if (!got || a !== 22'h200005 || {cpu_ok, vid_ok} !== 2'b11 || {cpu_data, vid_data} !== 32'h2222_1111) begin
         failures++; $display("FAIL dls_refill got=%b/%h/%b/%h exp=1/200005/11/22221111", got, a, {cpu_ok, vid_ok}, {cpu_data, vid_data});
      end
   endtask

   task automatic test_addr_change();
      logic [AW-1:0] a; bit got, dropped;
      cpu_addr = 22'h000777; @(negedge clk);
      checks++;
      if (!sdram_rd || sdram_addr !== 22'h000777) begin
         failures++; $display("FAIL chg_start got=%b/%h exp=1/000777", sdram_rd, sdram_addr);
      end
      cpu_addr = 22'h000778;
      prog_addr = 22'h000050; prog_data = 8'h5A; prog_mask = 2'b00; prog_we = 1'b1;
      @(negedge clk); prog_we = 1'b0;
      do_read(16'h7777, a, got, dropped);
      checks++;
      if (!got || a !== 22'h000777 || cpu_ok !== 1'b0) begin
         failures++; $display("FAIL chg_stale got=%b/%h/%b exp=1/000777/0", got, a, cpu_ok);
      end
      @(negedge clk);
      checks++;
      if (!sdram_wr || sdram_rd || sdram_addr !== 22'h000050 || sdram_din !== 16'h5A5A) begin
         failures++; $display("FAIL chg_wr_after_rd got=%b/%b/%h/%h exp=1/0/000050/5a5a", sdram_wr, sdram_rd, sdram_addr, sdram_din);
      end
      man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
      do_read(16'h7878, a, got, dropped);
      checks++;
      if (!got || a !== 22'h000778 || cpu_ok !== 1'b1 || cpu_data !== 16'h7878) begin
         failures++; $display("FAIL chg_reread got=%b/%h/%b/%h exp=1/000778/1/7878", got, a, cpu_ok, cpu_data);
      end
   endtask

   task automatic test_reset_mid_read();
      cpu_addr = 22'h000999; @(negedge clk);
      checks++;
      if (!sdram_rd || sdram_addr !== 22'h000999) begin
         failures++; $display("FAIL rmr_start got=%b/%h exp=1/000999", sdram_rd, sdram_addr);
      end
      man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      checks++;
      if ({sdram_rd, sdram_wr, cpu_ok, vid_ok} !== 4'b0000) begin
         failures++; $display("FAIL rmr_idle got=%b exp=0000", {sdram_rd, sdram_wr, cpu_ok, vid_ok});
      end
      man_rdy = 1'b1; man_dout = 16'h9999; @(negedge clk); man_rdy = 1'b0;
      checks++;
      if (cpu_ok !== 1'b0 || cpu_data !== 16'h0000 || !sdram_rd || sdram_addr !== 22'h000005) begin
         failures++; $display("FAIL rmr_late_rdy got=%b/%h/%b/%h exp=0/0000/1/000005", cpu_ok, cpu_data, sdram_rd, sdram_addr);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] pool [6];
      int cw, vw, maxw, nok;
      pool = '{22'h000100, 22'h200100, 22'h000101, 22'h3FFFFF, 22'h000000, 22'h012345};
      cpu_req = 1'b0; vid_req = 1'b0; man_ack = 1'b0; man_rdy = 1'b0;
      rst = 1'b1; @(negedge clk); rst = 1'b0; auto_en = 1'b1;
      cw = 0; vw = 0; maxw = 0; nok = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (cpu_ok) begin
            nok++; checks++;
            if (cpu_data !== mem_word(cpu_addr)) begin
               failures++; $display("FAIL rand_cpu_data addr=%h got=%h exp=%h", cpu_addr, cpu_data, mem_word(cpu_addr));
            end
         end
         if (vid_ok) begin
            nok++; checks++;
            if (vid_data !== mem_word(vid_addr)) begin
               failures++; $display("FAIL rand_vid_data addr=%h got=%h exp=%h", vid_addr, vid_data, mem_word(vid_addr));
            end
         end
         if (cpu_req && !cpu_ok) cw++; else cw = 0;
         if (vid_req && !vid_ok) vw++; else vw = 0;
         if (cw > maxw) maxw = cw;
         if (vw > maxw) maxw = vw;
         if (!cpu_req || cpu_ok) begin
            cpu_req = ($urandom_range(0, 3) != 0); cpu_addr = pool[$urandom_range(0, 5)]; cw = 0;
         end else if ($urandom_range(0, 19) == 0) begin
            cpu_addr = pool[$urandom_range(0, 5)]; cw = 0;
         end
         if (!vid_req || vid_ok) begin
            vid_req = ($urandom_range(0, 3) != 0); vid_addr = pool[$urandom_range(0, 5)]; vw = 0;
         end else if ($urandom_range(0, 19) == 0) begin
            vid_addr = pool[$urandom_range(0, 5)]; vw = 0;
         end
      end
      auto_en = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
      checks++;
      if (maxw > 80) begin failures++; $display("FAIL rand_liveness got=%0d exp<=80", maxw); end
      checks++;
      if (nok < 50) begin failures++; $display("FAIL rand_ok_count got=%0d exp>=50", nok); end
   endtask

   initial begin
      checks = 0; failures = 0;
      man_ack = 1'b0; man_rdy = 1'b0; man_dout = 16'h0000;
      rst = 1'b1; downloading = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = 8'h00;
      prog_mask = 2'b11; cpu_req = 1'b0; vid_req = 1'b0; cpu_addr = '0; vid_addr = '0;
      test_reset();
      test_download();
      test_overflow();
      test_we_on_ack();
      test_contention();
      test_cache_hit();
      test_download_start();
      test_addr_change();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
